// File: rtl/shared_timer_arbiter.sv
// One prescaled countdown timer shared round-robin among N level requesters.
// Build option: define SHARED_TIMER_ABORT_EN to let the owner abort a run by dropping req.
module shared_timer_arbiter #(
    parameter int N        = 4,
    parameter int CW       = 16,
    parameter int PRESCALE = 100_000
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [N-1:0]    req,
    input  logic [N*CW-1:0] tc,
    output logic [N-1:0]    grant,
    output logic [N-1:0]    done,
    output logic            busy,
    output logic [CW-1:0]   remain
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] CNT_RELOAD = PW'(PRESCALE - 1);
    localparam logic [IW-1:0] LAST_IDX   = IW'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   ptr_q,   ptr_d;
    logic [CW-1:0]   q_q,     q_d;
    logic [PW-1:0]   cnt_q,   cnt_d;

    logic [CW-1:0]   tc_arr [N];
    logic            found;
    logic [IW-1:0]   sel;
    logic [IW-1:0]   cand;
    int              idx;
    logic [IW-1:0]   next_ptr;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            tc_arr[i] = tc[i*CW +: CW];
        end
    end

    // Round-robin pick: first requester at or after ptr, wrapping.
    always_comb begin
        found = 1'b0;
        sel   = ptr_q;
        cand  = '0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx  = (int'(ptr_q) + k) % N;
            cand = IW'(idx);
            if (!found && req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    assign next_ptr = (owner_q == LAST_IDX) ? '0 : owner_q + IW'(1);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    grant_d      = '0;
                    grant_d[sel] = 1'b1;
                    owner_d      = sel;
                    q_d          = tc_arr[sel];
                    cnt_d        = CNT_RELOAD;
                    state_d      = (tc_arr[sel] == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
`ifdef SHARED_TIMER_ABORT_EN
                if (!req[owner_q]) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    ptr_d   = next_ptr;
                end else
`endif
                begin
                    // q is held on the final tick so it never passes below 1 in RUN.
                    if (q_q == CW'(1) && cnt_q == '0) begin
                        state_d = ST_DONE;
                    end else if (cnt_q != '0) begin
                        cnt_d = cnt_q - PW'(1);
                    end else begin
                        cnt_d = CNT_RELOAD;
                        q_d   = q_q - CW'(1);
                    end
                end
            end
            ST_DONE: begin
                grant_d = '0;
                ptr_d   = next_ptr;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
        end
    end

    assign grant  = grant_q;
    assign done   = (state_q == ST_DONE) ? grant_q : '0;
    assign busy   = (state_q != ST_IDLE);
    assign remain = (state_q == ST_RUN) ? q_q : '0;

endmodule

// File: tb/tb_shared_timer_arbiter.sv
// Directed bench for shared_timer_arbiter: N=4, CW=8, PRESCALE=4 plus a PRESCALE=1 instance.
module tb_shared_timer_arbiter;

    localparam int N  = 4;
    localparam int CW = 8;

    logic            clk  = 1'b0;
    logic            rstn = 1'b0;
    logic [N-1:0]    req  = '0;
    logic [N*CW-1:0] tc   = '0;
    logic [N-1:0]    req1 = '0;
    logic [N*CW-1:0] tc1  = '0;

    logic [N-1:0]    grant, done, grant1, done1;
    logic            busy, busy1;
    logic [CW-1:0]   remain, remain1;

    int n_tests = 0;
    int n_fail  = 0;

    shared_timer_arbiter #(.N(N), .CW(CW), .PRESCALE(4)) u_dut (
        .clk(clk), .rstn(rstn), .req(req), .tc(tc),
        .grant(grant), .done(done), .busy(busy), .remain(remain)
    );

    shared_timer_arbiter #(.N(N), .CW(CW), .PRESCALE(1)) u_dut_p1 (
        .clk(clk), .rstn(rstn), .req(req1), .tc(tc1),
        .grant(grant1), .done(done1), .busy(busy1), .remain(remain1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int order [5] = '{0, 1, 2, 3, 0};
    int len;

    initial begin
        // reset state
        #1;
        check("rst_grant", grant, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_remain", remain, 0);
        step(2);
        rstn = 1'b1;
        step(1);

        // single request, tc=3
        req[0]      = 1'b1;
        tc[0*CW +: CW] = 8'd3;
        step(1);
        check("single_grant", grant, 1);
        check("single_busy", busy, 1);
        for (int c = 0; c < 12; c++) begin
            check("single_remain", remain, 3 - c / 4);
            check("single_nodone", done, 0);
            step(1);
        end
        check("single_done", done, 1);
        check("single_grant_at_done", grant, 1);
        check("single_remain_at_done", remain, 0);
        req[0] = 1'b0;
        step(1);
        check("single_grant_off", grant, 0);
        check("single_done_off", done, 0);
        check("single_idle", busy, 0);

        // round robin from reset release
        rstn = 1'b0;
        #1;
        req = 4'b1111;
        for (int i = 0; i < N; i++) tc[i*CW +: CW] = 8'd1;
        step(1);
        rstn = 1'b1;
        step(1);
        for (int k = 0; k < 5; k++) begin
            check("rr_grant", grant, 1 << order[k]);
            len = 0;
            while (grant != 0 && len < 10) begin
                if (done != 0) begin
                    check("rr_done", done, grant);
                    if (order[k] != 0 || k == 4) req[order[k]] = 1'b0;
                end
                len++;
                step(1);
            end
            check("rr_len", len, 5);
            if (k < 4) begin
                check("rr_gap", grant, 0);
                step(1);
            end
        end

        // zero count on requester 2
        tc[2*CW +: CW] = 8'd0;
        req[2] = 1'b1;
        step(1);
        check("zero_grant", grant, 4);
        check("zero_done", done, 4);
        check("zero_busy", busy, 1);
        check("zero_remain", remain, 0);
        req[2] = 1'b0;
        step(1);
        check("zero_busy_off", busy, 0);
        check("zero_grant_off", grant, 0);
        check("zero_done_off", done, 0);

        // abort: req[1] tc=5 dropped 6 cycles after grant, req[2] pending
        tc[1*CW +: CW] = 8'd5;
        tc[2*CW +: CW] = 8'd1;
        req = 4'b0110;
        step(1);
        check("abort_grant1", grant, 2);
        step(6);
        req[1] = 1'b0;
        step(1);
`ifdef SHARED_TIMER_ABORT_EN
        check("abort_grant_off", grant, 0);
        check("abort_nodone", done, 0);
        check("abort_idle", busy, 0);
        step(1);
`else
        check("noabort_grant_held", grant, 2);
        for (int c = 7; c < 20; c++) begin
            check("noabort_nodone", done, 0);
            step(1);
        end
        check("noabort_done", done, 2);
        step(1);
        check("noabort_grant_off", grant, 0);
        step(1);
`endif
        check("abort_next_grant", grant, 4);
        step(4);
        check("abort_next_done", done, 4);
        req[2] = 1'b0;
        step(2);
        check("abort_end_idle", busy, 0);

        // reset mid-RUN, then ptr restarts at 0
        tc[3*CW +: CW] = 8'd3;
        req = 4'b1000;
        step(1);
        check("midrst_grant", grant, 8);
        check("midrst_remain3", remain, 3);
        step(4);
        check("midrst_remain2", remain, 2);
        rstn = 1'b0;
        #1;
        check("midrst_grant0", grant, 0);
        check("midrst_done0", done, 0);
        check("midrst_busy0", busy, 0);
        check("midrst_remain0", remain, 0);
        req = 4'b1010;
        tc[1*CW +: CW] = 8'd1;
        tc[3*CW +: CW] = 8'd1;
        step(1);
        rstn = 1'b1;
        step(1);
        check("midrst_first", grant, 2);
        step(4);
        check("midrst_done1", done, 2);
        req[1] = 1'b0;
        step(2);
        check("midrst_second", grant, 8);
        step(4);
        check("midrst_done3", done, 8);
        req[3] = 1'b0;
        step(2);
        check("midrst_idle", busy, 0);

        // max count with PRESCALE=1
        check("max_idle", busy1, 0);
        req1[0] = 1'b1;
        tc1[0*CW +: CW] = 8'd255;
        step(1);
        check("max_grant", grant1, 1);
        for (int c = 0; c < 255; c++) begin
            check("max_remain", remain1, 255 - c);
            check("max_nodone", done1, 0);
            step(1);
        end
        check("max_done", done1, 1);
        check("max_remain_done", remain1, 0);
        req1[0] = 1'b0;
        step(1);
        check("max_grant_off", grant1, 0);
        check("max_busy_off", busy1, 0);
        check("max_remain_off", remain1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/shared_timer_arbiter.md
# shared_timer_arbiter

Shares one prescaled countdown timer among `N` requesters using round-robin arbitration and a level request / grant / done handshake. It sits between the per-channel front ends (debouncers, blink and timeout logic) and the single tick-counting datapath, so that only one prescaler and countdown register exist per design. Exactly one requester owns the timer at a time. The owner is told via a one-cycle `done` pulse when its programmed tick count expires.

## Interface
Parameters:
- `N`, 4: number of requesters, at least 2.
- `CW`, 16: width of the tick count.
- `PRESCALE`, 100_000: clk cycles per tick, at least 1.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `req`  in  N  level request, one bit per requester.
- `tc`  in  N*CW  tick counts; requester i uses `tc[i*CW +: CW]`.
- `grant`  out  N  one-hot (or zero) owner indication, registered.
- `done`  out  N  one-cycle expiry pulse to the owner.
- `busy`  out  1  high when state is not IDLE.
- `remain`  out  CW  ticks remaining for the current owner; 0 when not in RUN.

## Operation
- State machine: IDLE, RUN, DONE.
  - IDLE: if any `req` bit is high, select the first requester with `req` high, scanning from `ptr` upward with wrap.
    - Register `grant[sel]` and `owner=sel`.
    - Load `q = tc[sel]` and `cnt = PRESCALE-1`.
    - If `tc[sel]==0`, go to DONE; otherwise go to RUN.
  - RUN: each cycle, if `cnt!=0` then `cnt--`. Otherwise `cnt = PRESCALE-1` and `q--`. When `q==1` and `cnt==0`, go to DONE.
  - DONE: stays exactly one cycle. Then clear `grant`, set `ptr = (owner+1) mod N`, and go to IDLE.
- `done[i] = (state==DONE) & grant[i]`, decoded from registered state only.
- `tc` is sampled only on the IDLE->RUN/DONE edge; later changes are ignored.
- Requester protocol:
  - A requester holds `req` until it sees `done`.
  - If `req` is still high after `done`, it is a new request, served after the other pending requesters.
- `remain = q` in RUN, 0 in IDLE and DONE.
- `q` never wraps: it is reloaded only at grant and stops at DONE.
- Reset values: `grant=0`, `done=0`, `busy=0`, `remain=0`, state IDLE, `ptr=0`, `q=0`, `cnt=0`.

## Timing
- A request sampled high in IDLE at edge T gives `grant` high from edge T (first visible cycle T+1, called G).
- Done cycle:
  - `tc>0`: `done` is high in cycle G + tc*PRESCALE.
  - `tc=0`: `done` is high in cycle G, together with `grant`.
- `grant` stays high through the done cycle and is low the following cycle.
- Back-to-back turnaround: a done cycle D is followed by IDLE in D+1, so the next grant appears in D+2.
- Simultaneous requests at reset release: requester 0 is served first, then 1, 2, …, N-1.
- `rstn` low at any time, including mid-RUN or during DONE:
  - All outputs drop to reset values asynchronously.
  - No `done` is issued.
  - `ptr` returns to 0.
- `PRESCALE=1`: `cnt` stays 0 and `q` decrements every cycle.

## Configuration
- Macro `SHARED_TIMER_ABORT_EN` defined (abort feature compiled in):
  - In RUN, if `req[owner]` is low, the next state is IDLE.
  - `grant` clears, no `done` pulse is issued, and `ptr` advances to owner+1.
  - `req` drop during DONE is ignored.
- Macro undefined:
  - `req[owner]` is ignored after grant.
  - The timer always runs to completion and `done` pulses normally.

## Test plan
Use `N=4`, `CW=8`, `PRESCALE=4` unless stated otherwise.
- Single request: `req[0]` with `tc=3` from idle.
  - `grant[0]` rises 1 cycle after `req` is sampled.
  - `remain` reads 3, 2, 1 for 4 cycles each.
  - `done[0]` high exactly 12 cycles after the `grant` rise; `grant[0]` low one cycle later.
- Round-robin order: `req=4'b1111` at reset release, all `tc=1`, each requester drops `req` on its `done` except requester 0, which re-raises it.
  - Grant order is 0, 1, 2, 3, 0.
  - Each grant lasts 5 cycles, with a 1-cycle gap between grants.
- Zero count: `req[2]` with `tc=0`.
  - `grant[2]` and `done[2]` are high in the same single cycle.
  - `busy` is high for 1 cycle.
- Abort: `req[1]` with `tc=5`, dropped 6 cycles after grant.
  - With `SHARED_TIMER_ABORT_EN`: `grant[1]` low next cycle, `done` never pulses, and a pending `req[2]` is granted 1 cycle later.
  - Without the macro: `done[1]` at grant+20.
- Reset mid-RUN: assert `rstn` low at `remain=2`.
  - `grant`, `done`, `busy` and `remain` are 0 immediately.
  - After release with `req=4'b1010`, requester 1 is granted first.
- Maximum count: `PRESCALE=1`, `tc=255`.
  - `remain` steps 255 down to 1, one per cycle.
  - `done` at grant+255, with no wrap.
